// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target SDA engine.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   localparam logic [I2C_ADDR_W-1:0] I2C_GEN_CALL_ADDR = 7'h00;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      RD_BYTE,
      RD_ACK,
      WAIT_STOP
   } i2c_slv_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus line with rise/fall pulses
// generated on the synchronised level.
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_in,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_reg <= '1;
         prev_reg <= 1'b1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_in};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign o_level = sync_reg[SYNC_STAGES-1];
   assign o_rise  = o_level & ~prev_reg;
   assign o_fall  = ~o_level & prev_reg;

endmodule

// File: rtl/i2c_slave_sda.sv
// I2C target SDA engine: address match, write-byte delivery and read-byte shifting.
// Optional general-call write support is enabled by defining I2C_GENERAL_CALL_EN.
module i2c_slave_sda
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLV_ADDR    = 7'h42,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_scl,
   inout  tri                    io_sda,
   output logic [I2C_BYTE_W-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_tx_req,
   input  logic [I2C_BYTE_W-1:0] i_tx_data,
   output logic                  o_busy
);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;
   logic start_det, stop_det, addr_hit;

   i2c_slv_state_e        state_reg, state_next;
   logic [2:0]            bit_cnt_reg, bit_cnt_next;
   logic [I2C_BYTE_W-1:0] shift_reg, shift_next;
   logic [I2C_BYTE_W-1:0] tx_reg, tx_next;
   logic [I2C_BYTE_W-1:0] rx_data_reg, rx_data_next;
   logic                  rx_valid_reg, rx_valid_next;
   logic                  rw_reg, rw_next;
   logic                  sda_low_reg, sda_low_next;
   logic                  busy_reg, busy_next;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_in      (i_scl),
      .o_level   (scl_s),
      .o_rise    (scl_rise),
      .o_fall    (scl_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_in      (io_sda),
      .o_level   (sda_s),
      .o_rise    (sda_rise),
      .o_fall    (sda_fall)
   );

   assign start_det = scl_s & sda_fall;
   assign stop_det  = scl_s & sda_rise;

   // shift_reg[6:0] holds the address when the R/W bit (sda_s) is being sampled.
`ifdef I2C_GENERAL_CALL_EN
   assign addr_hit = (shift_reg[6:0] == SLV_ADDR) ||
                     ((shift_reg[6:0] == I2C_GEN_CALL_ADDR) && !sda_s);
`else
   assign addr_hit = (shift_reg[6:0] == SLV_ADDR);
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= '0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         rw_reg       <= 1'b0;
         sda_low_reg  <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         rw_reg       <= rw_next;
         sda_low_reg  <= sda_low_next;
         busy_reg     <= busy_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      rw_next       = rw_reg;
      sda_low_next  = sda_low_reg;
      busy_next     = busy_reg;

      if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = '0;
         sda_low_next = 1'b0;
         busy_next    = 1'b0;
      end else if (stop_det) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         sda_low_next = 1'b0;
         busy_next    = 1'b0;
      end else begin
         case (state_reg)
            ADDR: begin
               if (scl_rise) begin
                  shift_next   = {shift_reg[6:0], sda_s};
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     rw_next    = sda_s;
                     state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               // First fall starts the ACK pulse, second fall ends it.
               if (scl_fall) begin
                  if (!sda_low_reg) begin
                     sda_low_next = 1'b1;
                     busy_next    = 1'b1;
                  end else if (rw_reg) begin
                     state_next   = RD_BYTE;
                     bit_cnt_next = '0;
                     tx_next      = {i_tx_data[6:0], 1'b0};
                     sda_low_next = ~i_tx_data[7];
                  end else begin
                     state_next   = WR_BYTE;
                     bit_cnt_next = '0;
                     sda_low_next = 1'b0;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shift_next = {shift_reg[6:0], sda_s};
               end
               if (scl_fall) begin
                  if (bit_cnt_reg == 3'd7) begin
                     rx_data_next  = shift_reg;
                     rx_valid_next = 1'b1;
                     sda_low_next  = 1'b1;
                     state_next    = WR_ACK;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_low_next = 1'b0;
                  bit_cnt_next = '0;
                  state_next   = WR_BYTE;
               end
            end
            RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_reg == 3'd7) begin
                     sda_low_next = 1'b0;
                     state_next   = RD_ACK;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                     tx_next      = {tx_reg[6:0], 1'b0};
                     sda_low_next = ~tx_reg[7];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && sda_s) begin
                  state_next = WAIT_STOP;
               end else if (scl_fall) begin
                  state_next   = RD_BYTE;
                  bit_cnt_next = '0;
                  tx_next      = {i_tx_data[6:0], 1'b0};
                  sda_low_next = ~i_tx_data[7];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The read-byte request must coincide with the fall that loads i_tx_data.
   always_comb begin
      o_tx_req = 1'b0;
      if (scl_fall && !start_det && !stop_det) begin
         if ((state_reg == ADDR_ACK && sda_low_reg && rw_reg) || state_reg == RD_ACK) begin
            o_tx_req = 1'b1;
         end
      end
   end

   assign o_rx_data  = rx_data_reg;
   assign o_rx_valid = rx_valid_reg;
   assign o_busy     = busy_reg;
   assign io_sda     = sda_low_reg ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_slave_sda.md
Name: i2c_slave_sda

Overview:
- I2C target (slave) SDA engine; the responder on the same open-drain bus the master SDA logic drives.
- Oversamples SCL and SDA on the system clock and detects START, repeated START and STOP.
- Receives and matches the 7-bit address, ACKs it, then delivers write bytes to local logic or shifts read bytes out.
- Drives SDA open-drain only (low or Z), never high.

Parameters:
- SLV_ADDR, 7'h42, own 7-bit target address.
- SYNC_STAGES, 2, synchroniser depth for SCL/SDA (minimum 2).

Ports:
- i_clk  input  1  system clock; must be at least 8x the SCL frequency.
- i_reset_n  input  1  asynchronous active-low reset.
- i_scl  input  1  bus SCL; input only, no clock stretching.
- io_sda  inout(tri)  1  bus SDA; io_sda = sda_low ? 1'b0 : 1'bz.
- o_rx_data  output  8  last byte written by master.
- o_rx_valid  output  1  one-cycle pulse; o_rx_data valid.
- o_tx_req  output  1  one-cycle pulse requesting the next read byte.
- i_tx_data  input  8  read byte; sampled in the cycle o_tx_req is high.
- o_busy  output  1  high from addressed ACK until STOP or repeated START.

Behaviour:
- Reset values while i_reset_n is low, applied asynchronously:
  - SDA released (Z); state IDLE.
  - o_rx_data=0, o_rx_valid=0, o_tx_req=0, o_busy=0.
  - Reset mid-transfer releases SDA immediately.
- Synchronisation and edge events:
  - SCL and SDA each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised values: scl_rise, scl_fall.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- Bit timing:
  - SDA is sampled only on scl_rise.
  - The driven SDA changes only on scl_fall.
  - Data bits are MSB first; a 3-bit counter plus an ACK phase gives 9 SCL pulses per byte.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (addr[6:0], R/W).
    - On the 8th scl_rise, a match (addr==SLV_ADDR) -> ADDR_ACK.
    - No match -> WAIT_STOP; SDA never driven.
  - ADDR_ACK: pull SDA low from the 8th scl_fall to the 9th scl_fall; o_busy set.
    - At the 9th scl_fall: R/W=0 -> WR_BYTE; R/W=1 -> RD_BYTE.
  - WR_BYTE: shift 8 bits.
    - On the 8th scl_fall: o_rx_data updates and o_rx_valid pulses for one cycle in the same cycle.
    - Then WR_ACK pulls SDA low until the next scl_fall, then returns to WR_BYTE.
  - RD_BYTE:
    - o_tx_req pulses on the scl_fall that enters the state; i_tx_data is latched in that cycle.
    - Bit 7 is driven in that same cycle: 0 -> low, 1 -> Z.
    - Remaining bits change on each subsequent scl_fall.
    - After the 8th bit the slave releases SDA for RD_ACK.
  - RD_ACK: sample master ACK on the 9th scl_rise.
    - 0 (ACK) -> RD_BYTE at the next scl_fall, with a new o_tx_req.
    - 1 (NACK) -> WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Events in any state:
  - STOP -> IDLE: SDA released, o_busy=0, no o_rx_valid for a partial byte.
  - START in any state, including a repeated START mid-byte -> ADDR with the counter cleared; the partial byte is discarded.
- Simultaneous events: START/STOP take priority over SCL edge processing in the same cycle.

Optional Feature:
- Macro I2C_GENERAL_CALL_EN.
  - Defined: address 7'h00 with R/W=0 is ACKed and handled as a write (WR_BYTE path).
  - Defined: address 7'h00 with R/W=1 is NACKed -> WAIT_STOP.
  - Undefined: 7'h00 is treated as a non-matching address.

Decomposition:
- Package i2c_pkg:
  - enum i2c_slv_state_e {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP}.
  - I2C_ADDR_W=7, I2C_BYTE_W=8.
  - I2C_GEN_CALL_ADDR=7'h00.
- Sub-module i2c_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs; instantiated for SCL and for SDA.

Test Plan:
- Write to 0x42 with data 0xA5, 0x3C, then STOP -> ACK low on 9th pulse ×3; o_rx_valid pulses twice with 0xA5 then 0x3C; o_busy returns to 0 after STOP.
- Write to 0x43 -> SDA never driven low; no o_rx_valid; state WAIT_STOP until STOP.
- Read from 0x42 with i_tx_data=0x96 then 0x0F, master ACK then NACK -> bus shows bits 10010110 then 00001111; o_tx_req pulses exactly twice; SDA released after NACK.
- Repeated START after 4 data bits of a write, then read from 0x42 -> no o_rx_valid; address ACKed; read proceeds normally.
- Assert i_reset_n low while slave is pulling SDA low in ADDR_ACK -> io_sda is Z in the same cycle; all outputs are 0.
- With I2C_GENERAL_CALL_EN, write to 0x00 with data 0x06 -> ACK and o_rx_valid with 0x06; without the macro -> no ACK.
